// File: rtl/sa_stream_sequencer_if.sv
// Valid/ready vector stream between the sequencer and its producer/consumer.
// Each beat carries one SA_SIZE-element vector.
interface sa_stream_sequencer_if #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8
);
  logic                                      valid;
  logic                                      ready;
  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]   data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/sa_stream_sequencer.sv
// Feeds a non-stalling systolic array: skews accepted vectors onto the rows,
// de-skews bottom-row outputs into a FWFT FIFO, credit-meters input, runs the job FSM.
module sa_stream_sequencer #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int OUT_FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    start,
  input  logic [COUNT_WIDTH-1:0]                  num_vectors,
  output logic                                    busy,
  output logic                                    done,
  sa_stream_sequencer_if.slave                    in_s,
  sa_stream_sequencer_if.master                   out_m,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_inputs,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_outputs
);
  localparam int N  = SA_SIZE;
  localparam int W  = ACTIVATION_SIZE;
  localparam int D  = OUT_FIFO_DEPTH;
  localparam int VS = 2 * N - 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   done_q, done_d;
  logic [VS-1:0]          vld_pipe_q, vld_pipe_d;
  vec_t                   mem_q [D];
  vec_t                   mem_d [D];
  logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  vec_t                   aligned;
  logic                   accept, pop, push;

  assign accept      = in_s.valid && in_s.ready;
  assign pop         = out_m.valid && out_m.ready;
  assign push        = vld_pipe_q[VS-1];
  assign in_s.ready  = (state_q == RUN) && (credits_q != '0);
  assign out_m.valid = (cnt_q != '0);
  assign out_m.data  = out_m.valid ? mem_q[rd_q] : '0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  // Row r sees an accepted element r+1 cycles after the accept edge; zeros otherwise.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [W-1:0] pipe_q [r+1];
    logic [W-1:0] pipe_d [r+1];
    always_comb begin
      pipe_d[0] = accept ? in_s.data[r] : '0;
      for (int k = 1; k <= r; k++) pipe_d[k] = pipe_q[k-1];
    end
    always_ff @(posedge clk) begin
      if (!resetn) pipe_q <= '{default: '0};
      else         pipe_q <= pipe_d;
    end
    assign sa_inputs[r] = pipe_q[r];
  end

  // Column c emerges c cycles after column 0, so it waits N-1-c cycles to line up.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    if (c == N - 1) begin : g_pass
      assign aligned[c] = sa_outputs[c];
    end else begin : g_reg
      localparam int L = N - 1 - c;
      logic [W-1:0] pipe_q [L];
      logic [W-1:0] pipe_d [L];
      always_comb begin
        pipe_d[0] = sa_outputs[c];
        for (int k = 1; k < L; k++) pipe_d[k] = pipe_q[k-1];
      end
      always_ff @(posedge clk) begin
        if (!resetn) pipe_q <= '{default: '0};
        else         pipe_q <= pipe_d;
      end
      assign aligned[c] = pipe_q[L-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    credits_d  = credits_q;
    vld_pipe_d = {vld_pipe_q[VS-2:0], accept};
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !accept) credits_d = credits_q + CW'(1);

    if (push) begin
      mem_d[wr_q] = aligned;
      wr_d        = (wr_q == PW'(D - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) rd_d = (rd_q == PW'(D - 1)) ? '0 : rd_q + PW'(1);

    case (state_q)
      IDLE: if (start) begin
        rem_d = num_vectors;
        if (num_vectors == '0) done_d  = 1'b1;
        else                   state_d = RUN;
      end
      RUN: if (accept) begin
        rem_d = rem_q - COUNT_WIDTH'(1);
        if (rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish on the edge that pops the final result, so done follows it by one cycle.
        if (vld_pipe_q == '0 && (cnt_q == '0 || (cnt_q == CW'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      credits_q  <= CW'(D);
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      credits_q  <= credits_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && cnt_q == CW'(D)));

endmodule
